aclk_multi_controller: RTL
==========================

// Module: aclk_multi_controller
// PURPOSE
//  Keypad/button FSM for the 24-hr alarm clock, successor to the single-alarm controller.
//  - Supports NUM_ALARMS alarm slots and DIGITS-digit keypad entry.
//  - Entry timeout is KEY_TIMEOUT seconds.
//  - A commit with an incomplete entry is rejected.
//  - Drives the key shift register, alarm register bank, time loader and display mux.
// PARAMETERS
//  NUM_ALARMS   4   number of alarm slots (>=2)
//  DIGITS       4   digits needed for a valid entry (HH:MM)
//  KEY_TIMEOUT  10  one_second pulses with no key before an entry is abandoned
//  NOKEY        10  key code meaning "no key pressed"
//  SW = $clog2(NUM_ALARMS), CW = $clog2(DIGITS+1), TW = $clog2(KEY_TIMEOUT+1) (localparams)
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high
//  one_second     in   1   one-cycle pulse per second
//  time_button    in   1   commit entry as current time (level, held >=1 cycle)
//  alarm_button   in   1   show alarm (idle) / commit entry as alarm (entry)
//  slot_button    in   1   advance selected alarm slot (idle only)
//  key            in   4   0-9 = digit, NOKEY = none; others ignored like NOKEY
//  reset_count    out  1   clear seconds counter (with load_new_c)
//  load_new_a     out  1   write entry into alarm slot alarm_slot
//  show_a         out  1   display alarm slot alarm_slot
//  show_new_time  out  1   display key buffer
//  load_new_c     out  1   load entry into current-time counter
//  shift          out  1   shift key into buffer
//  alarm_slot     out  SW  selected alarm slot
//  digit_count    out  CW  digits entered in current entry
//  entry_error    out  1   one-cycle pulse: incomplete commit rejected
// BEHAVIOUR
//  Moore FSM; outputs decode registered state, one cycle after the causing input edge.
//  States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME, ERROR.
//  Reset:
//  - state=SHOW_TIME; alarm_slot=0; digit_count=0; timer=0; all 1-bit outputs 0.
//  - Reset mid-entry discards the entry; no load pulse is issued.
//  SHOW_TIME:
//  - Priority alarm_button > valid key > slot_button.
//  - alarm_button -> SHOW_ALARM.
//  - Valid key -> KEY_STORED (digit_count cleared to 0 first).
//  - slot_button -> alarm_slot+1, wraps NUM_ALARMS-1 -> 0; stays SHOW_TIME.
//  SHOW_ALARM: show_a=1; stay while alarm_button=1; release -> SHOW_TIME.
//  KEY_STORED (1 cycle): shift=1; digit_count+1; timer cleared -> KEY_WAITED.
//  KEY_WAITED: waits for key==NOKEY -> KEY_ENTRY. A held key never re-shifts.
//  KEY_ENTRY:
//  - Priority alarm_button > time_button > key > timeout.
//  - Commit with digit_count==DIGITS: SET_ALARM_TIME / SET_CURRENT_TIME.
//  - Commit with digit_count<DIGITS -> ERROR.
//  - Valid key with digit_count<DIGITS -> KEY_STORED.
//  - Valid key with digit_count==DIGITS is ignored.
//  show_new_time=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY.
//  Timeout: in KEY_WAITED/KEY_ENTRY, timer counts one_second pulses.
//  - Pulse when timer==KEY_TIMEOUT-1 -> SHOW_TIME; no load, no error.
//  - A one_second pulse in the same cycle as a commit or key is ignored for timeout.
//  SET_ALARM_TIME (1 cycle): load_new_a=1 with alarm_slot stable -> SHOW_TIME.
//  SET_CURRENT_TIME (1 cycle): load_new_c=1, reset_count=1 -> SHOW_TIME.
//  ERROR (1 cycle): entry_error=1 -> SHOW_TIME.
//  digit_count holds its value in SHOW_TIME until the next entry starts.
//  timer saturates; never wraps.
//  alarm_slot changes only in SHOW_TIME.
// TESTING
//  1. Key 1,2,3,0 (each held 3 cycles, NOKEY gaps), then time_button -> 4 shift pulses;
//     then 1 cycle load_new_c=1 & reset_count=1; back to SHOW_TIME.
//  2. slot_button x2, then 4 digits, then alarm_button -> load_new_a=1 with alarm_slot=2.
//  3. slot_button x NUM_ALARMS -> alarm_slot wraps to 0.
//  4. Key 2,3 then alarm_button -> entry_error 1 cycle; load_new_a stays 0.
//     Also: 5th key after 4 digits -> no shift; digit_count stays 4.
//  5. Key 5 then 10 one_second pulses -> SHOW_TIME, show_new_time=0, no load pulse.
//     Also: a key at pulse 9 restarts the timeout.
//  6. Key held 20 cycles -> exactly 1 shift pulse.
//     Also: reset asserted during KEY_ENTRY -> all outputs 0 next cycle, alarm_slot=0.

Source files
------------

// File: rtl/aclk_multi_controller.sv
// ---------------------------------------------------------------------------
// aclk_multi_controller
// Keypad/button controller for the 24-hour alarm clock with several alarm slots.
// A Moore FSM sequences digit entry into the key buffer and commits the entry as
// the current time or as the selected alarm. It abandons an entry after a quiet
// period and rejects a commit when too few digits have been entered.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   one_second     in   one-cycle pulse per second
//   time_button    in   commit entry as current time
//   alarm_button   in   show alarm (idle) / commit entry as alarm (entry)
//   slot_button    in   advance selected alarm slot (idle only)
//   key[3:0]       in   0-9 digit; anything else means no key
//   reset_count    out  clear seconds counter
//   load_new_a     out  write entry into alarm slot alarm_slot
//   show_a         out  display alarm slot alarm_slot
//   show_new_time  out  display key buffer
//   load_new_c     out  load entry into current-time counter
//   shift          out  shift key into buffer
//   alarm_slot     out  selected alarm slot
//   digit_count    out  digits entered in current entry
//   entry_error    out  one-cycle pulse on a rejected incomplete commit
// ---------------------------------------------------------------------------
module aclk_multi_controller #(
  parameter  int unsigned NUM_ALARMS  = 4,
  parameter  int unsigned DIGITS      = 4,
  parameter  int unsigned KEY_TIMEOUT = 10,
  parameter  int unsigned NOKEY       = 10,
  localparam int unsigned SW          = $clog2(NUM_ALARMS),
  localparam int unsigned CW          = $clog2(DIGITS + 1),
  localparam int unsigned TW          = $clog2(KEY_TIMEOUT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          one_second,
  input  logic          time_button,
  input  logic          alarm_button,
  input  logic          slot_button,
  input  logic [3:0]    key,
  output logic          reset_count,
  output logic          load_new_a,
  output logic          show_a,
  output logic          show_new_time,
  output logic          load_new_c,
  output logic          shift,
  output logic [SW-1:0] alarm_slot,
  output logic [CW-1:0] digit_count,
  output logic          entry_error
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME,
    ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [SW-1:0] r_alarm_slot;
  logic [CW-1:0] r_digit_count;
  logic [TW-1:0] r_timer;

  logic w_key_valid;
  logic w_full;
  logic w_timeout;
  logic w_slot_inc;
  logic w_count_clr;
  logic w_timer_inc;

  // Codes 10-15 are treated exactly like NOKEY.
  assign w_key_valid = (key <= 4'd9) && (key != 4'(NOKEY));
  assign w_full      = (r_digit_count == CW'(DIGITS));
  assign w_timeout   = one_second && (r_timer == TW'(KEY_TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= SHOW_TIME;
      r_alarm_slot  <= '0;
      r_digit_count <= '0;
      r_timer       <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_count_clr)
        r_digit_count <= '0;
      else if (r_state == KEY_STORED)
        r_digit_count <= r_digit_count + CW'(1);

      // Each stored key restarts the quiet-period timer; the timer saturates.
      if (r_state == KEY_STORED)
        r_timer <= '0;
      else if (w_timer_inc && (r_timer != TW'(KEY_TIMEOUT)))
        r_timer <= r_timer + TW'(1);

      if (w_slot_inc) begin
        if (r_alarm_slot == SW'(NUM_ALARMS - 1))
          r_alarm_slot <= '0;
        else
          r_alarm_slot <= r_alarm_slot + SW'(1);
      end
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_slot_inc   = 1'b0;
    w_count_clr  = 1'b0;
    w_timer_inc  = 1'b0;
    unique case (r_state)
      SHOW_TIME: begin
        if (alarm_button) begin
          w_next_state = SHOW_ALARM;
        end else if (w_key_valid) begin
          w_next_state = KEY_STORED;
          w_count_clr  = 1'b1;
        end else if (slot_button) begin
          w_slot_inc = 1'b1;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) w_next_state = SHOW_TIME;
      end
      KEY_STORED: begin
        w_next_state = KEY_WAITED;
      end
      KEY_WAITED: begin
        if (w_timeout) begin
          w_next_state = SHOW_TIME;
        end else begin
          w_timer_inc = one_second;
          if (!w_key_valid) w_next_state = KEY_ENTRY;
        end
      end
      KEY_ENTRY: begin
        // A commit or any valid key (even an ignored one) masks the second pulse.
        if (alarm_button) begin
          w_next_state = w_full ? SET_ALARM_TIME : ERROR;
        end else if (time_button) begin
          w_next_state = w_full ? SET_CURRENT_TIME : ERROR;
        end else if (w_key_valid) begin
          if (!w_full) w_next_state = KEY_STORED;
        end else if (w_timeout) begin
          w_next_state = SHOW_TIME;
        end else begin
          w_timer_inc = one_second;
        end
      end
      SET_ALARM_TIME:   w_next_state = SHOW_TIME;
      SET_CURRENT_TIME: w_next_state = SHOW_TIME;
      ERROR:            w_next_state = SHOW_TIME;
      default:          w_next_state = SHOW_TIME;
    endcase
  end

  // Moore output decode of the registered state.
  always_comb begin
    reset_count   = 1'b0;
    load_new_a    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    load_new_c    = 1'b0;
    shift         = 1'b0;
    entry_error   = 1'b0;
    unique case (r_state)
      SHOW_ALARM: show_a = 1'b1;
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:     show_new_time = 1'b1;
      KEY_ENTRY:      show_new_time = 1'b1;
      SET_ALARM_TIME: load_new_a = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      ERROR:   entry_error = 1'b1;
      default: ;
    endcase
  end

  assign alarm_slot  = r_alarm_slot;
  assign digit_count = r_digit_count;

endmodule
